// File: rtl/pipe_pkg.sv
// Shared types for the decode/execute boundary: forwarding source select and
// the packed ID/EX pipeline register layout.
package pipe_pkg;

    localparam int PIPE_WIDTH = 16;
    localparam int PIPE_AW    = 4;
    localparam int PIPE_CTRLW = 8;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  isload;
        logic [PIPE_AW-1:0]    wa;
        logic [PIPE_CTRLW-1:0] ctrl;
        logic [PIPE_WIDTH-1:0] opa;
        logic [PIPE_WIDTH-1:0] opb;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding mux: picks the youngest in-flight writer of ra
// (EX, then MEM, then WB) ahead of the register file read data.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int WIDTH        = PIPE_WIDTH,
    parameter int ADDRESSWIDTH = PIPE_AW
) (
    input  logic [ADDRESSWIDTH-1:0] ra,
    input  logic [WIDTH-1:0]        rf_data,
    input  logic                    ex_fwd_en,
    input  logic [ADDRESSWIDTH-1:0] ex_wa,
    input  logic [WIDTH-1:0]        ex_data,
    input  logic                    mem_we,
    input  logic [ADDRESSWIDTH-1:0] mem_wa,
    input  logic [WIDTH-1:0]        mem_data,
    input  logic                    wb_we,
    input  logic [ADDRESSWIDTH-1:0] wb_wa,
    input  logic [WIDTH-1:0]        wb_data,
    output logic [WIDTH-1:0]        data,
    output fwd_sel_t                sel
);

    always_comb begin
        sel  = FWD_RF;
        data = rf_data;
        if (ex_fwd_en && (ex_wa == ra)) begin
            sel  = FWD_EX;
            data = ex_data;
        end else if (mem_we && (mem_wa == ra)) begin
            sel  = FWD_MEM;
            data = mem_data;
        end else if (wb_we && (wb_wa == ra)) begin
            // regfile writes on the edge, so this cycle's read is still stale
            sel  = FWD_WB;
            data = wb_data;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: forwarding, load-use stall and the ID/EX register.
// Optional OPERAND_STALL_CNT_EN adds a saturating load-use stall counter output.
module operand_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH        = PIPE_WIDTH,
    parameter int ADDRESSWIDTH = PIPE_AW,
    parameter int CTRLWIDTH    = PIPE_CTRLW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [ADDRESSWIDTH-1:0] id_ra1,
    input  logic [ADDRESSWIDTH-1:0] id_ra2,
    input  logic [ADDRESSWIDTH-1:0] id_wa,
    input  logic                    id_we,
    input  logic                    id_isload,
    input  logic [CTRLWIDTH-1:0]    id_ctrl,
    input  logic [WIDTH-1:0]        rd1,
    input  logic [WIDTH-1:0]        rd2,
    input  logic [WIDTH-1:0]        ex_result,
    input  logic [ADDRESSWIDTH-1:0] mem_wa,
    input  logic                    mem_we,
    input  logic [WIDTH-1:0]        mem_result,
    input  logic [ADDRESSWIDTH-1:0] wb_wa,
    input  logic                    wb_we,
    input  logic [WIDTH-1:0]        wb_result,
    input  logic                    ex_ready,
    input  logic                    flush,
    output logic                    stall_id,
    output logic                    ex_valid,
    output logic [WIDTH-1:0]        ex_opa,
    output logic [WIDTH-1:0]        ex_opb,
    output logic [ADDRESSWIDTH-1:0] ex_wa,
    output logic                    ex_we,
    output logic                    ex_isload,
    output logic [CTRLWIDTH-1:0]    ex_ctrl
`ifdef OPERAND_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    id_ex_t          id_ex;
    logic            ex_fwd_en;
    logic            lu;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    fwd_sel_t        opa_sel;
    fwd_sel_t        opb_sel;

    // A load in EX has no result yet; it is handled by the load-use stall instead.
    assign ex_fwd_en = id_ex.valid & id_ex.we & ~id_ex.isload;

    fwd_mux #(.WIDTH(WIDTH), .ADDRESSWIDTH(ADDRESSWIDTH)) u_fwd_a (
        .ra        (id_ra1),
        .rf_data   (rd1),
        .ex_fwd_en (ex_fwd_en),
        .ex_wa     (id_ex.wa),
        .ex_data   (ex_result),
        .mem_we    (mem_we),
        .mem_wa    (mem_wa),
        .mem_data  (mem_result),
        .wb_we     (wb_we),
        .wb_wa     (wb_wa),
        .wb_data   (wb_result),
        .data      (opa),
        .sel       (opa_sel)
    );

    fwd_mux #(.WIDTH(WIDTH), .ADDRESSWIDTH(ADDRESSWIDTH)) u_fwd_b (
        .ra        (id_ra2),
        .rf_data   (rd2),
        .ex_fwd_en (ex_fwd_en),
        .ex_wa     (id_ex.wa),
        .ex_data   (ex_result),
        .mem_we    (mem_we),
        .mem_wa    (mem_wa),
        .mem_data  (mem_result),
        .wb_we     (wb_we),
        .wb_wa     (wb_wa),
        .wb_data   (wb_result),
        .data      (opb),
        .sel       (opb_sel)
    );

    always_comb begin
        if (!reset) begin
            assert (opa_sel != FWD_RF || opa == rd1);
            assert (opb_sel != FWD_RF || opb == rd2);
        end
    end

    assign lu = id_valid & id_ex.valid & id_ex.we & id_ex.isload &
                ((id_ex.wa == id_ra1) | (id_ex.wa == id_ra2));

    assign stall_id = lu | ~ex_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex <= '0;
        end else if (!ex_ready) begin
            id_ex <= id_ex;
        end else if (flush) begin
            id_ex.valid  <= 1'b0;
            id_ex.we     <= 1'b0;
            id_ex.isload <= 1'b0;
        end else if (lu) begin
            id_ex.valid  <= 1'b0;
            id_ex.we     <= 1'b0;
            id_ex.isload <= 1'b0;
        end else begin
            id_ex.valid  <= id_valid;
            id_ex.we     <= id_we & id_valid;
            id_ex.isload <= id_isload;
            id_ex.wa     <= id_wa;
            id_ex.ctrl   <= id_ctrl;
            id_ex.opa    <= opa;
            id_ex.opb    <= opb;
        end
    end

    assign ex_valid  = id_ex.valid;
    assign ex_we     = id_ex.we;
    assign ex_isload = id_ex.isload;
    assign ex_wa     = id_ex.wa;
    assign ex_ctrl   = id_ex.ctrl;
    assign ex_opa    = id_ex.opa;
    assign ex_opb    = id_ex.opb;

`ifdef OPERAND_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (lu && ex_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
